// File: rtl/servo_angle_ramp.sv
// servo_angle_ramp: slews a servo angle code toward a requested target at
// STEP_SIZE codes per STEP_CYCLES clocks, never overshooting the target.
// Optional feature macro: SERVO_RAMP_CLAMP_EN. When it is defined, targets
// above MAX_ANGLE are clamped and err is tied low. When it is undefined,
// such targets are dropped and err pulses for one cycle.
module servo_angle_ramp #(
  parameter int unsigned STEP_CYCLES = 480000,
  parameter int unsigned STEP_SIZE   = 1,
  parameter int unsigned MAX_ANGLE   = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] target_angle,
  input  logic       target_valid,
  output logic       target_ready,
  output logic [9:0] angle,
  output logic       busy,
  output logic       arrived,
  output logic       err
);

  // A single-cycle step period still needs a 1-bit timer.
  localparam int unsigned TW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [TW-1:0]     TC      = TW'(STEP_CYCLES - 1);
  localparam logic [9:0]        CENTER  = 10'd90;
  localparam logic [9:0]        MAX_A   = 10'(MAX_ANGLE);
  localparam logic [9:0]        STEP10  = 10'(STEP_SIZE);
  localparam logic signed [10:0] STEP11 = 11'(STEP_SIZE);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RAMP = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [9:0]    angle_q, angle_d;
  logic [9:0]    tgt_q, tgt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          arrived_q, arrived_d;
  logic          ready_q, ready_d;

  logic                accept;
  logic                in_range;
  logic                take;
  logic [9:0]          tgt_in;
  logic [9:0]          tgt_new;
  logic signed [10:0]  diff;
  logic signed [10:0]  mag;
  logic [9:0]          stepped;
  logic                terminal;

`ifndef SERVO_RAMP_CLAMP_EN
  logic err_q, err_d;
`endif

  // Target acceptance and range handling.
  always_comb begin
    accept   = target_valid & ready_q;
    in_range = (target_angle <= MAX_A);
`ifdef SERVO_RAMP_CLAMP_EN
    tgt_in = in_range ? target_angle : MAX_A;
    take   = accept;
`else
    tgt_in = target_angle;
    take   = accept & in_range;
    err_d  = accept & ~in_range;
`endif
    tgt_new = take ? tgt_in : tgt_q;
  end

  // One ramp step toward the stored target. When the remaining distance fits
  // within a step, land exactly on the target so the angle cannot overshoot.
  always_comb begin
    diff     = $signed({1'b0, tgt_q}) - $signed({1'b0, angle_q});
    mag      = diff[10] ? -diff : diff;
    terminal = (timer_q == TC);
    if (mag <= STEP11)  stepped = tgt_q;
    else if (diff[10])  stepped = angle_q - STEP10;
    else                stepped = angle_q + STEP10;
  end

  // Next-state logic for IDLE/RAMP, the step timer and the arrived pulse.
  // A step on the same edge as a retarget uses the old target, while the
  // arrival check compares against the newly stored one.
  always_comb begin
    state_d   = state_q;
    angle_d   = angle_q;
    tgt_d     = tgt_q;
    timer_d   = timer_q;
    arrived_d = 1'b0;
    ready_d   = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (take) begin
          tgt_d = tgt_in;
          if (tgt_in == angle_q) begin
            arrived_d = 1'b1;
          end else begin
            timer_d = '0;
            state_d = S_RAMP;
          end
        end
      end
      default: begin
        tgt_d = tgt_new;
        if (terminal) begin
          timer_d = '0;
          angle_d = stepped;
        end else begin
          timer_d = timer_q + TW'(1);
        end
        if (angle_d == tgt_new) begin
          state_d   = S_IDLE;
          arrived_d = 1'b1;
        end
      end
    endcase
  end

  // State registers; reset recentres the servo and drops any pending target.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      angle_q   <= CENTER;
      tgt_q     <= CENTER;
      timer_q   <= '0;
      arrived_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      angle_q   <= angle_d;
      tgt_q     <= tgt_d;
      timer_q   <= timer_d;
      arrived_q <= arrived_d;
      ready_q   <= ready_d;
    end
  end

`ifdef SERVO_RAMP_CLAMP_EN
  assign err = 1'b0;
`else
  // Registered rejection pulse for out-of-range targets.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) err_q <= 1'b0;
    else        err_q <= err_d;
  end
  assign err = err_q;
`endif

  assign target_ready = ready_q;
  assign angle        = angle_q;
  assign busy         = (state_q == S_RAMP);
  assign arrived      = arrived_q;

endmodule

// File: tb/tb_servo_angle_ramp.sv
// Directed bench for servo_angle_ramp with STEP_CYCLES=4. It uses two
// instances, one with STEP_SIZE=1 and one with STEP_SIZE=5. Expected ramp
// values are produced by a step model into a queue and popped at each step.
module tb_servo_angle_ramp;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] tgt1, tgt5;
  logic       tv1, tv5;
  logic       rdy1, rdy5, bsy1, bsy5, arr1, arr5, er1, er5;
  logic [9:0] a1, a5;

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  servo_angle_ramp #(.STEP_CYCLES(4), .STEP_SIZE(1), .MAX_ANGLE(180)) u1 (
    .clk(clk), .reset(reset), .target_angle(tgt1), .target_valid(tv1),
    .target_ready(rdy1), .angle(a1), .busy(bsy1), .arrived(arr1), .err(er1));

  servo_angle_ramp #(.STEP_CYCLES(4), .STEP_SIZE(5), .MAX_ANGLE(180)) u5 (
    .clk(clk), .reset(reset), .target_angle(tgt5), .target_valid(tv5),
    .target_ready(rdy5), .angle(a5), .busy(bsy5), .arrived(arr5), .err(er5));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ang(input int s); return s != 0 ? {22'd0, a5} : {22'd0, a1}; endfunction
  function automatic logic [31:0] bsy(input int s); return s != 0 ? {31'd0, bsy5} : {31'd0, bsy1}; endfunction
  function automatic logic [31:0] arr(input int s); return s != 0 ? {31'd0, arr5} : {31'd0, arr1}; endfunction
  function automatic logic [31:0] erf(input int s); return s != 0 ? {31'd0, er5} : {31'd0, er1}; endfunction

  task automatic drive(input int s, input int t, input logic v);
    if (s != 0) begin tgt5 = 10'(t); tv5 = v; end
    else        begin tgt1 = 10'(t); tv1 = v; end
  endtask

  task automatic accept(input int s, input int t);
    @(negedge clk);
    drive(s, t, 1'b1);
    @(posedge clk);
    #1;
    drive(s, 0, 1'b0);
  endtask

  // Wait n edges: angle must hold prev until the n-th edge, then read exp.
  task automatic step_wait(input int s, input int n, input int prev, input int exp, input bit last);
    for (int i = 1; i < n; i++) begin
      @(posedge clk); #1;
      chk("hold", ang(s), prev);
    end
    @(posedge clk); #1;
    chk("step_angle", ang(s), exp);
    chk("step_arrived", arr(s), {31'd0, last});
    chk("step_busy", bsy(s), {31'd0, !last});
    chk("step_err", erf(s), 0);
  endtask

  task automatic ramp_check(input int s, input int start, input int t, input int step);
    int a, d, e, prev;
    a = start;
    while (a != t) begin
      d = t - a;
      if (d > 0) a = a + ((d < step) ? d : step);
      else       a = a - ((-d < step) ? -d : step);
      exp_q.push_back(a);
    end
    accept(s, t);
    chk("ramp_busy_start", bsy(s), 1);
    chk("ramp_angle_start", ang(s), start);
    prev = start;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      step_wait(s, 4, prev, e, exp_q.size() == 0);
      prev = e;
    end
    @(posedge clk); #1;
    chk("ramp_arrived_drop", arr(s), 0);
    chk("ramp_final", ang(s), t);
  endtask

  initial begin
    reset = 1'b0;
    tgt1 = '0; tgt5 = '0; tv1 = 1'b0; tv5 = 1'b0;
    #23;
    chk("rst_angle1", ang(0), 90);
    chk("rst_angle5", ang(1), 90);
    chk("rst_ready1", {31'd0, rdy1}, 0);
    chk("rst_busy1", bsy(0), 0);
    chk("rst_arrived1", arr(0), 0);
    chk("rst_err1", erf(0), 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready1", {31'd0, rdy1}, 1);
    chk("rel_ready5", {31'd0, rdy5}, 1);
    chk("rel_arrived", arr(0), 0);
    chk("rel_err", erf(0), 0);
    chk("rel_angle", ang(0), 90);

    // Small ramp up and a long ramp down ending on a partial step.
    ramp_check(0, 90, 93, 1);
    ramp_check(1, 90, 2, 5);

    // Target equal to current angle in IDLE.
    accept(0, 93);
    chk("eq_arrived", arr(0), 1);
    chk("eq_busy", bsy(0), 0);
    @(posedge clk); #1;
    chk("eq_arrived_drop", arr(0), 0);
    chk("eq_angle", ang(0), 93);

    // Asynchronous reset in the middle of a ramp.
    accept(0, 100);
    step_wait(0, 4, 93, 94, 1'b0);
    step_wait(0, 4, 94, 95, 1'b0);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("async_angle1", ang(0), 90);
    chk("async_angle5", ang(1), 90);
    chk("async_busy", bsy(0), 0);
    chk("async_ready", {31'd0, rdy1}, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("async_rel_busy", bsy(0), 0);
    chk("async_rel_angle", ang(0), 90);
    chk("async_rel_arrived", arr(0), 0);

    // Retarget mid-ramp; the step phase stays on the original 4-cycle grid.
    accept(0, 100);
    step_wait(0, 4, 90, 91, 1'b0);
    step_wait(0, 4, 91, 92, 1'b0);
    step_wait(0, 4, 92, 93, 1'b0);
    accept(0, 91);
    chk("rt_busy", bsy(0), 1);
    chk("rt_angle", ang(0), 93);
    step_wait(0, 3, 93, 92, 1'b0);
    step_wait(0, 4, 92, 91, 1'b1);

    // Out-of-range target from centre.
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
`ifdef SERVO_RAMP_CLAMP_EN
    ramp_check(0, 90, 180, 1);
    chk("clamp_err", erf(0), 0);
`else
    accept(0, 200);
    chk("oor_err", erf(0), 1);
    chk("oor_busy", bsy(0), 0);
    chk("oor_angle", ang(0), 90);
    chk("oor_arrived", arr(0), 0);
    @(posedge clk); #1;
    chk("oor_err_drop", erf(0), 0);
    repeat (5) @(posedge clk);
    #1;
    chk("oor_angle_hold", ang(0), 90);
    chk("oor_busy_hold", bsy(0), 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
